// File: rtl/tdc_edge_decoder.sv
`default_nettype none
// ============================================================================
// tdc_edge_decoder
// Decodes 16-tap thermometer samples into an edge position and averages
// 2^AVG_LOG2 samples per measurement; TDC_BUBBLE_FIX_EN selects popcount decode.
// Revision: 1.0 - initial release
// ============================================================================
module tdc_edge_decoder #(
  parameter int AVG_LOG2 = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] EDGE_IN,
  input  logic        IN_VALID,
  input  logic        START,
  output logic        BUSY,
  output logic [4:0]  POS_OUT,
  output logic        ERR_OUT,
  output logic        OUT_VALID,
  input  logic        OUT_READY
);

  localparam int AW = 5 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [4:0]      pos_out_q, pos_out_d;
  logic            err_out_q, err_out_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [4:0]      w_pos;
  logic            w_bubble;
  logic            w_seen_zero;
  logic [AW-1:0]   w_acc_sum;
  logic            w_err_sum;

  // Single pass over the taps: bubble = any 1 above the lowest 0.
  always_comb begin
    w_bubble    = 1'b0;
    w_seen_zero = 1'b0;
`ifdef TDC_BUBBLE_FIX_EN
    w_pos       = 5'd0;
`else
    w_pos       = 5'd16;
`endif
    for (int i = 0; i < 16; i++) begin
`ifdef TDC_BUBBLE_FIX_EN
      w_pos = w_pos + 5'(EDGE_IN[i]);
`else
      if (!EDGE_IN[i] && !w_seen_zero) w_pos = 5'(i);
`endif
      if (EDGE_IN[i] && w_seen_zero) w_bubble = 1'b1;
      if (!EDGE_IN[i]) w_seen_zero = 1'b1;
    end
  end

  assign w_acc_sum = acc_q + AW'(w_pos);
  assign w_err_sum = err_q | w_bubble;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    pos_out_d   = pos_out_q;
    err_out_d   = err_out_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_ACCUM: begin
        if (IN_VALID) begin
          acc_d = w_acc_sum;
          cnt_d = cnt_q + 1'b1;
          err_d = w_err_sum;
          if (cnt_q == LAST_CNT) begin
            state_d     = S_HOLD;
            pos_out_d   = w_acc_sum[AW-1:AVG_LOG2];
            err_out_d   = w_err_sum;
            out_valid_d = 1'b1;
            busy_d      = 1'b0;
          end
        end
      end
      S_HOLD: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          if (START) begin
            state_d = S_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      pos_out_q   <= 5'd0;
      err_out_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      pos_out_q   <= pos_out_d;
      err_out_q   <= err_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign BUSY      = busy_q;
  assign POS_OUT   = pos_out_q;
  assign ERR_OUT   = err_out_q;
  assign OUT_VALID = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_tdc_edge_decoder.sv
`default_nettype none
// ============================================================================
// tb_tdc_edge_decoder
// Directed-vector bench for tdc_edge_decoder with AVG_LOG2=2.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tdc_edge_decoder;

  logic        CLK;
  logic        RST;
  logic [15:0] EDGE_IN;
  logic        IN_VALID;
  logic        START;
  logic        BUSY;
  logic [4:0]  POS_OUT;
  logic        ERR_OUT;
  logic        OUT_VALID;
  logic        OUT_READY;

  int n_checks;
  int n_errors;

  tdc_edge_decoder #(.AVG_LOG2(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EDGE_IN   (EDGE_IN),
    .IN_VALID  (IN_VALID),
    .START     (START),
    .BUSY      (BUSY),
    .POS_OUT   (POS_OUT),
    .ERR_OUT   (ERR_OUT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  // One accepted sample, then `gaps` idle cycles with garbage on EDGE_IN.
  task automatic send(input logic [15:0] s, input int gaps);
    EDGE_IN  = s;
    IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    EDGE_IN  = 16'hFFFF;
    for (int g = 0; g < gaps; g++) step();
  endtask

  task automatic ack();
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    RST       = 1'b0;
    EDGE_IN   = 16'h0000;
    IN_VALID  = 1'b0;
    START     = 1'b0;
    OUT_READY = 1'b0;

    // Reset state
    #23;
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("rst_pos", {27'd0, POS_OUT}, 32'd0);
    chk("rst_err", {31'd0, ERR_OUT}, 32'd0);
    step();
    RST = 1'b1;
    IN_VALID = 1'b1;
    EDGE_IN  = 16'h00FF;
    step();
    step();
    IN_VALID = 1'b0;
    chk("idle_no_start_busy", {31'd0, BUSY}, 32'd0);
    chk("idle_no_start_valid", {31'd0, OUT_VALID}, 32'd0);

    // 4x 0x001F -> 5
    pulse_start();
    chk("t1_busy", {31'd0, BUSY}, 32'd1);
    send(16'h001F, 0);
    send(16'h001F, 0);
    send(16'h001F, 0);
    chk("t1_not_yet_valid", {31'd0, OUT_VALID}, 32'd0);
    send(16'h001F, 0);
    chk("t1_valid", {31'd0, OUT_VALID}, 32'd1);
    chk("t1_pos", {27'd0, POS_OUT}, 32'd5);
    chk("t1_err", {31'd0, ERR_OUT}, 32'd0);
    chk("t1_busy_done", {31'd0, BUSY}, 32'd0);
    ack();
    chk("t1_ack_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("t1_ack_pos_kept", {27'd0, POS_OUT}, 32'd5);
    chk("t1_ack_idle", {31'd0, BUSY}, 32'd0);

    // Gapped samples 0+16+8+4 = 28 -> 7; START mid-ACCUM must be ignored
    pulse_start();
    send(16'h0000, 2);
    send(16'hFFFF, 1);
    START = 1'b1;
    step();
    START = 1'b0;
    send(16'h00FF, 3);
    chk("t2_mid_valid", {31'd0, OUT_VALID}, 32'd0);
    send(16'h000F, 0);
    chk("t2_valid", {31'd0, OUT_VALID}, 32'd1);
    chk("t2_pos", {27'd0, POS_OUT}, 32'd7);
    chk("t2_err", {31'd0, ERR_OUT}, 32'd0);
    ack();

    // Bubble 0x0017: leading ones 3, popcount 4
    pulse_start();
    for (int k = 0; k < 4; k++) send(16'h0017, 0);
    chk("t3_valid", {31'd0, OUT_VALID}, 32'd1);
    chk("t3_err", {31'd0, ERR_OUT}, 32'd1);
`ifdef TDC_BUBBLE_FIX_EN
    chk("t3_pos", {27'd0, POS_OUT}, 32'd4);
`else
    chk("t3_pos", {27'd0, POS_OUT}, 32'd3);
`endif
    ack();

    // 1,1,1,2 -> 5>>2 = 1; error flag cleared by the new START
    pulse_start();
    send(16'h0001, 0);
    send(16'h0001, 1);
    send(16'h0001, 0);
    send(16'h0003, 0);
    chk("t4_valid", {31'd0, OUT_VALID}, 32'd1);
    chk("t4_pos", {27'd0, POS_OUT}, 32'd1);
    chk("t4_err", {31'd0, ERR_OUT}, 32'd0);

    // HOLD with OUT_READY=0 while START / IN_VALID toggle
    EDGE_IN = 16'h0F0F;
    for (int c = 0; c < 10; c++) begin
      START    = c[0];
      IN_VALID = ~c[0];
      step();
      chk("t5_hold_valid", {31'd0, OUT_VALID}, 32'd1);
      chk("t5_hold_pos", {27'd0, POS_OUT}, 32'd1);
      chk("t5_hold_err", {31'd0, ERR_OUT}, 32'd0);
      chk("t5_hold_busy", {31'd0, BUSY}, 32'd0);
    end
    IN_VALID  = 1'b0;
    START     = 1'b1;
    OUT_READY = 1'b1;
    step();
    START     = 1'b0;
    OUT_READY = 1'b0;
    chk("t5_restart_busy", {31'd0, BUSY}, 32'd1);
    chk("t5_restart_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("t5_restart_pos_kept", {27'd0, POS_OUT}, 32'd1);

    // Async reset mid-ACCUM after 2 samples
    send(16'h0003, 0);
    send(16'h0003, 0);
    RST = 1'b0;
    #1;
    chk("t6_rst_busy", {31'd0, BUSY}, 32'd0);
    chk("t6_rst_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("t6_rst_pos", {27'd0, POS_OUT}, 32'd0);
    chk("t6_rst_err", {31'd0, ERR_OUT}, 32'd0);
    step();
    RST = 1'b1;
    send(16'h0003, 0);
    send(16'h0003, 0);
    chk("t6_post_rst_idle", {31'd0, BUSY}, 32'd0);
    chk("t6_post_rst_novalid", {31'd0, OUT_VALID}, 32'd0);
    pulse_start();
    for (int k = 0; k < 3; k++) send(16'h0003, 0);
    chk("t6_three_not_valid", {31'd0, OUT_VALID}, 32'd0);
    send(16'h0003, 0);
    chk("t6_valid", {31'd0, OUT_VALID}, 32'd1);
    chk("t6_pos", {27'd0, POS_OUT}, 32'd2);
    chk("t6_err", {31'd0, ERR_OUT}, 32'd0);
    ack();
    chk("t6_ack_valid", {31'd0, OUT_VALID}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tdc_edge_decoder.md
TDC_EDGE_DECODER -- requirements
Module: tdc_edge_decoder

Interface
REQ-001 SHALL have parameter AVG_LOG2, default 2: log2 of the number of samples averaged per measurement (range 0..4).
REQ-002 SHALL have port CLK  input  1  rising-edge clock, the same clock that samples the delay-line taps.
REQ-003 SHALL have port RST  input  1  reset; RST is asynchronous and active-low, and the clock is CLK.
REQ-004 SHALL have port EDGE_IN  input  16  thermometer sample; bit 0 = first delay tap, bit 15 = last tap.
REQ-005 SHALL have port IN_VALID  input  1  EDGE_IN holds a new sample this cycle.
REQ-006 SHALL have port START  input  1  single-cycle request to begin a measurement.
REQ-007 SHALL have port BUSY  output  1  high in the ACCUM state.
REQ-008 SHALL have port POS_OUT  output  5  averaged edge position, 0..16.
REQ-009 SHALL have port ERR_OUT  output  1  at least one non-thermometer (bubble) sample occurred in the measurement.
REQ-010 SHALL have port OUT_VALID  output  1  POS_OUT and ERR_OUT are valid.
REQ-011 SHALL have port OUT_READY  input  1  consumer accepts the result.

Function
REQ-012 SHALL implement an FSM with states IDLE, ACCUM and HOLD; the reset state is IDLE.
REQ-013 IDLE: START=1 -> ACCUM; the accumulator, sample counter and error flag are cleared on the same edge.
REQ-014 ACCUM: each cycle with IN_VALID=1 SHALL add the decoded position to the accumulator and increment the sample counter; cycles with IN_VALID=0 SHALL change nothing.
REQ-015 Decode: the position SHALL be the count of consecutive 1s starting at bit 0 (EDGE_IN=0x0000 -> 0, EDGE_IN=0xFFFF -> 16), unless overridden by REQ-029.
REQ-016 Bubble: a sample is a bubble when any 1 lies above the lowest 0; a bubble SHALL set the sticky error flag.
REQ-017 The accumulator SHALL be 5+AVG_LOG2 bits wide and SHALL never overflow.
REQ-018 On the edge that accepts sample number 2^AVG_LOG2, the block SHALL move to HOLD and register POS_OUT = (accumulator including this sample) >> AVG_LOG2, truncated, with ERR_OUT = the flag including this sample and OUT_VALID=1.
REQ-019 HOLD: POS_OUT, ERR_OUT and OUT_VALID SHALL stay stable; IN_VALID SHALL be ignored.
REQ-020 HOLD with OUT_READY=1: on the next edge the block SHALL clear OUT_VALID and go to IDLE; if START=1 on the same cycle, it SHALL instead go directly to ACCUM with clears.
REQ-021 START SHALL be ignored in ACCUM, and in HOLD while OUT_READY=0.
REQ-022 POS_OUT and ERR_OUT SHALL retain their last values after the handshake until the next result is registered.
REQ-023 BUSY SHALL be a registered output, high only in ACCUM.

Reset
REQ-024 RST=0 SHALL immediately force IDLE with the accumulator, sample counter and error flag cleared.
REQ-025 RST=0 SHALL immediately force POS_OUT=0, ERR_OUT=0, OUT_VALID=0 and BUSY=0.
REQ-026 Reset asserted mid-ACCUM or mid-HOLD SHALL discard the partial or unacknowledged result.
REQ-027 After release, nothing SHALL happen until a new START.

Configuration
REQ-028 SHALL support the macro TDC_BUBBLE_FIX_EN.
REQ-029 With TDC_BUBBLE_FIX_EN defined, the decoded position SHALL be the population count of EDGE_IN (0..16); ERR_OUT is still set on bubbles.
REQ-030 Without TDC_BUBBLE_FIX_EN, the decoded position SHALL be the leading-ones count per REQ-015, and no popcount logic SHALL be instantiated.

Verification (AVG_LOG2=2)
REQ-031 SHALL cover: START, then 4x EDGE_IN=0x001F -> OUT_VALID=1 on the 4th accepting edge, POS_OUT=5, ERR_OUT=0.
REQ-032 SHALL cover: samples 0x0000, 0xFFFF, 0x00FF, 0x000F with IN_VALID gaps between them -> POS_OUT=7 (28>>2).
REQ-033 SHALL cover: 4x 0x0017 -> ERR_OUT=1; POS_OUT=4 with TDC_BUBBLE_FIX_EN, POS_OUT=3 without it.
REQ-034 SHALL cover: samples decoding to 1, 1, 1, 2 -> POS_OUT=1 (truncation of 5>>2).
REQ-035 SHALL cover: OUT_READY=0 for 10 cycles while START and IN_VALID toggle -> outputs unchanged; then OUT_READY=1 with START=1 -> ACCUM, BUSY=1, OUT_VALID=0.
REQ-036 SHALL cover: RST pulsed low after 2 samples in ACCUM -> all outputs 0 immediately; a new START plus 4x 0x0003 -> POS_OUT=2.
